// File: rtl/counter_date_if.sv
// Date-counter bus: day tick, set-mode controls and up/down pulses in; BCD date digits and year tick out.
// Pure wiring with no latency; level/pulse signalling only, so there is no backpressure.
interface counter_date_if;
    logic       tick_day;
    logic       mode_day;
    logic       mode_month;
    logic       mode_year;
    logic       up;
    logic       down;
    logic [3:0] day_unit;
    logic [3:0] day_ten;
    logic [3:0] month_unit;
    logic [3:0] month_ten;
    logic [3:0] year_unit;
    logic [3:0] year_ten;
    logic [3:0] year_hundred;
    logic [3:0] year_thousand;
    logic       tick_year;

    modport master (
        output tick_day, mode_day, mode_month, mode_year, up, down,
        input  day_unit, day_ten, month_unit, month_ten,
        input  year_unit, year_ten, year_hundred, year_thousand, tick_year
    );

    modport slave (
        input  tick_day, mode_day, mode_month, mode_year, up, down,
        output day_unit, day_ten, month_unit, month_ten,
        output year_unit, year_ten, year_hundred, year_thousand, tick_year
    );
endinterface

// File: rtl/counter_date.sv
// BCD calendar date (DD/MM/YYYY, leap-aware) with run and set modes; outputs registered, 1-cycle latency.
// No backpressure: every tick_day/up/down pulse is consumed on the edge that samples it.
module counter_date (
    input  logic           clk,
    input  logic           rst_n,
    counter_date_if.slave  bus
);

    logic [7:0]  r_day;
    logic [7:0]  r_month;
    logic [15:0] r_year;
    logic        r_tick_year;

    logic [7:0]  w_day_nxt;
    logic [7:0]  w_month_nxt;
    logic [15:0] w_year_nxt;
    logic        w_tick_nxt;
    logic [7:0]  w_last;
    logic        w_set;
    logic        w_step;

    function automatic logic [7:0] inc2(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec2(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Ripple carry/borrow across four BCD digits; wraps 9999<->0000 naturally.
    function automatic logic [15:0] inc4(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] dec4(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic div4(input logic [3:0] ten, input logic [3:0] unit);
        return ten[0] ? (unit == 4'd2 || unit == 4'd6)
                      : (unit == 4'd0 || unit == 4'd4 || unit == 4'd8);
    endfunction

    // A year ending in 00 is leap only if its century is divisible by 4.
    function automatic logic is_leap(input logic [15:0] y);
        return (y[7:0] == 8'h00) ? div4(y[15:12], y[11:8]) : div4(y[7:4], y[3:0]);
    endfunction

    function automatic logic [7:0] last_day(input logic [7:0] m, input logic leap);
        case (m)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] d, input logic [7:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign w_set  = bus.mode_day | bus.mode_month | bus.mode_year;
    assign w_step = bus.up ^ bus.down;
    assign w_last = last_day(r_month, is_leap(r_year));

    always_comb begin
        w_day_nxt   = r_day;
        w_month_nxt = r_month;
        w_year_nxt  = r_year;
        w_tick_nxt  = 1'b0;
        if (!w_set) begin
            if (bus.tick_day) begin
                if (r_day == w_last) begin
                    w_day_nxt = 8'h01;
                    if (r_month == 8'h12) begin
                        w_month_nxt = 8'h01;
                        w_year_nxt  = inc4(r_year);
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_month_nxt = inc2(r_month);
                    end
                end else begin
                    w_day_nxt = inc2(r_day);
                end
            end
        end else if (w_step) begin
            if (bus.mode_day) begin
                if (bus.up) begin
                    w_day_nxt = (r_day == w_last) ? 8'h01 : inc2(r_day);
                end else begin
                    w_day_nxt = (r_day == 8'h01) ? w_last : dec2(r_day);
                end
            end else if (bus.mode_month) begin
                if (bus.up) begin
                    w_month_nxt = (r_month == 8'h12) ? 8'h01 : inc2(r_month);
                end else begin
                    w_month_nxt = (r_month == 8'h01) ? 8'h12 : dec2(r_month);
                end
                w_day_nxt = clamp(r_day, last_day(w_month_nxt, is_leap(r_year)));
            end else begin
                w_year_nxt = bus.up ? inc4(r_year) : dec4(r_year);
                w_day_nxt  = clamp(r_day, last_day(r_month, is_leap(w_year_nxt)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day       <= 8'h01;
            r_month     <= 8'h01;
            r_year      <= 16'h2000;
            r_tick_year <= 1'b0;
        end else begin
            r_day       <= w_day_nxt;
            r_month     <= w_month_nxt;
            r_year      <= w_year_nxt;
            r_tick_year <= w_tick_nxt;
        end
    end

    assign bus.day_unit      = r_day[3:0];
    assign bus.day_ten       = r_day[7:4];
    assign bus.month_unit    = r_month[3:0];
    assign bus.month_ten     = r_month[7:4];
    assign bus.year_unit     = r_year[3:0];
    assign bus.year_ten      = r_year[7:4];
    assign bus.year_hundred  = r_year[11:8];
    assign bus.year_thousand = r_year[15:12];
    assign bus.tick_year     = r_tick_year;

endmodule
